// File: rtl/core_pkg.sv
// Shared types and constants for the fetch stage: fetch FSM states, word
// geometry and the instruction field positions decode relies on.
package core_pkg;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } fetch_state_t;

  localparam int XLEN         = 32;
  localparam int INSTR_BYTES  = 4;

  localparam int OP_LSB       = 0;
  localparam int OP_MSB       = 6;
  localparam int FUNCT3_LSB   = 12;
  localparam int FUNCT3_MSB   = 14;
  localparam int FUNCT7_5_BIT = 30;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO with occupancy count and single-cycle flush; used for the
// instruction buffer and for the PC tags of in-flight fetches.
module fetch_fifo #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 2,
  parameter int CW     = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [DATA_W-1:0] head,
  output logic [CW-1:0]     count
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic              empty;
  logic              full;
  logic              do_push;
  logic              do_pop;

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop & ~empty;
  // A pop frees the slot a same-cycle push lands in when the FIFO is full.
  assign do_push = push & (~full | do_pop);
  assign head    = mem[rd_ptr];

  // Entries are cleared on reset so the head reads zero out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= ptr_inc(wr_ptr);
      end
      if (do_pop) rd_ptr <= ptr_inc(rd_ptr);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(push && !flush && full && !pop));

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: credit-limited word requests, in-order tagged responses,
// redirect flush with response discard. FETCH_PERF_CNT_EN adds perf counters.
module fetch_unit
  import core_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC  = 32'h0000_0000,
  parameter int              BUF_DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_gnt,
  input  logic            imem_rvalid,
  input  logic [XLEN-1:0] imem_rdata,
  input  logic            redirect,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            instr_valid,
  input  logic            instr_ready,
  output logic [XLEN-1:0] instr,
  output logic [XLEN-1:0] instr_pc,
  output logic [6:0]      op_6_0,
  output logic [2:0]      funct3,
  output logic            funct7_5
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [XLEN-1:0] perf_fetched,
  output logic [XLEN-1:0] perf_discarded,
  output logic [XLEN-1:0] perf_stall
`endif
);

  localparam int              CW         = $clog2(BUF_DEPTH + 1);
  localparam logic [CW:0]     CREDIT_MAX = (CW + 1)'(BUF_DEPTH);
  localparam logic [XLEN-1:0] PC_ALIGN   = ~XLEN'(INSTR_BYTES - 1);

  fetch_state_t      state;
  logic [XLEN-1:0]   fetch_pc;
  logic [CW-1:0]     inflight;
  logic [CW-1:0]     discard_cnt;
  logic [CW-1:0]     inflight_nxt;
  logic [CW-1:0]     discard_nxt;
  logic [CW-1:0]     buf_count;
  logic [CW-1:0]     tag_count;
  logic [CW:0]       credit_used;
  logic [2*XLEN-1:0] buf_head;
  logic [XLEN-1:0]   tag_head;
  logic              grant;
  logic              rsp_live;
  logic              rsp_drop;
  logic              pop;

  // Buffered plus in-flight words may never exceed the buffer size, so every
  // live response is guaranteed a slot.
  assign credit_used = {1'b0, buf_count} + {1'b0, inflight};
  assign imem_req    = (state != BOOT) && !redirect && (credit_used < CREDIT_MAX);
  assign imem_addr   = fetch_pc;
  assign grant       = imem_req & imem_gnt;

  assign rsp_live    = imem_rvalid & ~redirect & (discard_cnt == '0);
  assign rsp_drop    = imem_rvalid & ~rsp_live;

  assign instr_valid = (buf_count != '0) & ~redirect;
  assign pop         = instr_valid & instr_ready;

  always_comb begin
    inflight_nxt = inflight + CW'(grant) - CW'(imem_rvalid);
    discard_nxt  = discard_cnt;
    if (redirect) begin
      // A response landing with the redirect is dropped here, not counted.
      discard_nxt = inflight - CW'(imem_rvalid);
    end else if (imem_rvalid && (discard_cnt != '0)) begin
      discard_nxt = discard_cnt - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= BOOT;
      fetch_pc    <= RESET_PC;
      inflight    <= '0;
      discard_cnt <= '0;
    end else begin
      inflight    <= inflight_nxt;
      discard_cnt <= discard_nxt;
      if (redirect) begin
        fetch_pc <= redirect_pc & PC_ALIGN;
      end else if (grant) begin
        fetch_pc <= fetch_pc + XLEN'(INSTR_BYTES);
      end
      case (state)
        BOOT:       state <= RUN;
        RUN, FLUSH: state <= (discard_nxt != '0) ? FLUSH : RUN;
        default:    state <= BOOT;
      endcase
    end
  end

  fetch_fifo #(
    .DATA_W (XLEN),
    .DEPTH  (BUF_DEPTH),
    .CW     (CW)
  ) u_tag_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (redirect),
    .push      (grant),
    .push_data (fetch_pc),
    .pop       (rsp_live),
    .head      (tag_head),
    .count     (tag_count)
  );

  fetch_fifo #(
    .DATA_W (2 * XLEN),
    .DEPTH  (BUF_DEPTH),
    .CW     (CW)
  ) u_instr_buf (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (redirect),
    .push      (rsp_live),
    .push_data ({imem_rdata, tag_head}),
    .pop       (pop),
    .head      (buf_head),
    .count     (buf_count)
  );

  assign instr    = buf_head[2*XLEN-1:XLEN];
  assign instr_pc = buf_head[XLEN-1:0];
  assign op_6_0   = instr[OP_MSB:OP_LSB];
  assign funct3   = instr[FUNCT3_MSB:FUNCT3_LSB];
  assign funct7_5 = instr[FUNCT7_5_BIT];

`ifdef FETCH_PERF_CNT_EN
  function automatic logic [XLEN-1:0] sat_inc(input logic [XLEN-1:0] v, input logic en);
    return (en && (v != '1)) ? v + XLEN'(1) : v;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_fetched   <= '0;
      perf_discarded <= '0;
      perf_stall     <= '0;
    end else begin
      perf_fetched   <= sat_inc(perf_fetched, pop);
      perf_discarded <= sat_inc(perf_discarded, rsp_drop);
      perf_stall     <= sat_inc(perf_stall, instr_ready & ~instr_valid);
    end
  end
`endif

  a_rsp_expected: assert property (@(posedge clk) disable iff (!rst_n)
    imem_rvalid |-> (inflight != '0));
  a_tags_match_live: assert property (@(posedge clk) disable iff (!rst_n)
    tag_count == (inflight - discard_cnt));
  a_flush_iff_discard: assert property (@(posedge clk) disable iff (!rst_n)
    (state == FLUSH) == (discard_cnt != '0));
  a_drop_accounted: assert property (@(posedge clk) disable iff (!rst_n)
    rsp_drop |-> (redirect || (discard_cnt != '0)));

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboarded bench for fetch_unit with a one-cycle-latency memory model.
module tb_fetch_unit;

  localparam int          DEPTH  = 2;
  localparam logic [31:0] RST_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic [6:0]  op_6_0;
  logic [2:0]  funct3;
  logic        funct7_5;

  int          n_tests = 0;
  int          n_fail  = 0;
  int          grant_cnt = 0;
  int          pop_cnt = 0;
  logic        resp_en = 1'b0;
  logic        hs_q = 1'b0;
  logic [31:0] hs_addr = '0;
  logic [31:0] exp_addr = RST_PC;
  logic [31:0] mon_pc;
  logic [31:0] mon_w;
  logic [31:0] pend[$];
  logic [31:0] exp_q[$];

  fetch_unit #(.RESET_PC(RST_PC), .BUF_DEPTH(DEPTH)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_gnt    (imem_gnt),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .instr       (instr),
    .instr_pc    (instr_pc),
    .op_6_0      (op_6_0),
    .funct3      (funct3),
    .funct7_5    (funct7_5)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0) return 32'h0000_0033;
    return (a * 32'h0001_0003) ^ 32'h4000_5013;
  endfunction

  // Memory: one response per accepted request, in order, one cycle after grant.
  initial begin
    imem_rvalid = 1'b0;
    imem_rdata  = '0;
    forever begin
      @(posedge clk);
      #1;
      if (!rst_n) begin
        pend.delete();
        imem_rvalid = 1'b0;
      end else begin
        if (hs_q) pend.push_back(hs_addr);
        if (resp_en && pend.size() > 0) begin
          imem_rvalid = 1'b1;
          imem_rdata  = mem_word(pend.pop_front());
        end else begin
          imem_rvalid = 1'b0;
          imem_rdata  = 32'hDEAD_BEEF;
        end
      end
    end
  end

  // Scoreboard: grants push expected PCs, pops are compared against them.
  always @(negedge clk) begin
    hs_q    = imem_req & imem_gnt;
    hs_addr = imem_addr;
    if (!rst_n) begin
      exp_q.delete();
      exp_addr = RST_PC;
    end else if (redirect) begin
      exp_q.delete();
      exp_addr = redirect_pc & ~32'h3;
    end else begin
      if (instr_valid && instr_ready) begin
        pop_cnt++;
        n_tests++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL pop_unexpected: got instr_pc=%h, required no pop", instr_pc);
        end else begin
          mon_pc = exp_q.pop_front();
          mon_w  = mem_word(mon_pc);
          if (instr_pc !== mon_pc || instr !== mon_w || op_6_0 !== mon_w[6:0] ||
              funct3 !== mon_w[14:12] || funct7_5 !== mon_w[30]) begin
            n_fail++;
            $display("FAIL pop_data: got pc=%h instr=%h op=%h f3=%h f7=%b, required pc=%h instr=%h",
                     instr_pc, instr, op_6_0, funct3, funct7_5, mon_pc, mon_w);
          end
        end
      end
      if (hs_q) begin
        grant_cnt++;
        n_tests++;
        if (imem_addr !== exp_addr) begin
          n_fail++;
          $display("FAIL req_addr: got %h, required %h", imem_addr, exp_addr);
        end
        exp_q.push_back(exp_addr);
        exp_addr = exp_addr + 32'd4;
      end
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; redirect = 1'b0; redirect_pc = '0;
    instr_ready = 1'b1; imem_gnt = 1'b1; resp_en = 1'b1;
    tick(3);
    n_tests++;
    if (imem_req !== 1'b0 || instr_valid !== 1'b0) begin
      n_fail++; $display("FAIL reset_ctrl: got req=%b valid=%b, required 0 0", imem_req, instr_valid);
    end
    n_tests++;
    if (instr !== 32'h0 || instr_pc !== 32'h0 || op_6_0 !== 7'h0 || funct3 !== 3'h0 || funct7_5 !== 1'b0) begin
      n_fail++; $display("FAIL reset_data: got instr=%h pc=%h, required zeros", instr, instr_pc);
    end
    rst_n = 1'b1;
    #1;
    n_tests++;
    if (imem_req !== 1'b0) begin
      n_fail++; $display("FAIL boot_no_req: got req=%b, required 0", imem_req);
    end
    tick();
    n_tests++;
    if (imem_req !== 1'b1 || imem_addr !== RST_PC) begin
      n_fail++; $display("FAIL first_req: got req=%b addr=%h, required 1 %h", imem_req, imem_addr, RST_PC);
    end
  endtask

  task automatic test_stream_decode();
    bit found = 0;
    int p0;
    for (int i = 0; i < 10 && !found; i++) begin
      if (instr_valid) found = 1; else tick();
    end
    n_tests++;
    if (!found) begin
      n_fail++; $display("FAIL first_valid: got no instr_valid in 10 cycles, required one");
    end else begin
      n_tests++;
      if (instr !== 32'h0000_0033 || instr_pc !== 32'h0 || op_6_0 !== 7'h33 || funct3 !== 3'h0 || funct7_5 !== 1'b0) begin
        n_fail++; $display("FAIL decode_first: got instr=%h pc=%h op=%h f3=%h f7=%b, required 00000033 0 33 0 0",
                           instr, instr_pc, op_6_0, funct3, funct7_5);
      end
    end
    p0 = pop_cnt;
    tick(30);
    n_tests++;
    if (pop_cnt - p0 < 12) begin
      n_fail++; $display("FAIL stream_rate: got %0d pops in 30 cycles, required at least 12", pop_cnt - p0);
    end
  endtask

  task automatic test_ready_stall();
    int g1;
    instr_ready = 1'b0;
    tick(5);
    g1 = grant_cnt;
    tick(5);
    n_tests++;
    if (imem_req !== 1'b0 || grant_cnt != g1) begin
      n_fail++; $display("FAIL stall_req: got req=%b grants=%0d, required 0 and %0d", imem_req, grant_cnt, g1);
    end
    n_tests++;
    if (exp_q.size() != DEPTH || instr_valid !== 1'b1) begin
      n_fail++; $display("FAIL stall_fill: got outstanding=%0d valid=%b, required %0d 1", exp_q.size(), instr_valid, DEPTH);
    end
    instr_ready = 1'b1;
    tick(10);
    n_tests++;
    if (grant_cnt <= g1) begin
      n_fail++; $display("FAIL stall_restart: got grants=%0d, required more than %0d", grant_cnt, g1);
    end
  endtask

  task automatic test_redirect_flush();
    bit found = 0;
    resp_en = 1'b0;
    tick(6);
    n_tests++;
    if (imem_req !== 1'b0 || pend.size() != 2 || instr_valid !== 1'b0) begin
      n_fail++; $display("FAIL flush_setup: got req=%b pending=%0d valid=%b, required 0 2 0", imem_req, pend.size(), instr_valid);
    end
    redirect = 1'b1; redirect_pc = 32'h0000_0102;
    tick();
    redirect = 1'b0;
    #1;
    n_tests++;
    if (imem_addr !== 32'h0000_0100 || imem_req !== 1'b0) begin
      n_fail++; $display("FAIL flush_addr: got addr=%h req=%b, required 00000100 0", imem_addr, imem_req);
    end
    resp_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_tests++;
      if (instr_valid !== 1'b0) begin
        n_fail++; $display("FAIL flush_drop: got valid=%b at cycle %0d, required 0", instr_valid, i);
      end
    end
    for (int i = 0; i < 10 && !found; i++) begin
      if (instr_valid) found = 1; else tick();
    end
    n_tests++;
    if (!found || instr_pc !== 32'h0000_0100) begin
      n_fail++; $display("FAIL flush_first_pc: got found=%b pc=%h, required 1 00000100", found, instr_pc);
    end
  endtask

  task automatic test_redirect_rvalid_pop();
    bit hit = 0;
    bit found = 0;
    for (int i = 0; i < 20 && !hit; i++) begin
      if (imem_rvalid && instr_valid && instr_ready) hit = 1; else tick();
    end
    n_tests++;
    if (!hit) begin
      n_fail++; $display("FAIL coincide_setup: got no rvalid+pop cycle in 20, required one");
      return;
    end
    redirect = 1'b1; redirect_pc = 32'h0000_2000;
    #1;
    n_tests++;
    if (instr_valid !== 1'b0) begin
      n_fail++; $display("FAIL coincide_pop_gate: got valid=%b during redirect, required 0", instr_valid);
    end
    tick();
    redirect = 1'b0;
    #1;
    n_tests++;
    if (instr_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h0000_2000) begin
      n_fail++; $display("FAIL coincide_after: got valid=%b req=%b addr=%h, required 0 1 00002000",
                         instr_valid, imem_req, imem_addr);
    end
    for (int i = 0; i < 10 && !found; i++) begin
      if (instr_valid) found = 1; else tick();
    end
    n_tests++;
    if (!found || instr_pc !== 32'h0000_2000) begin
      n_fail++; $display("FAIL coincide_first_pc: got found=%b pc=%h, required 1 00002000", found, instr_pc);
    end
  endtask

  task automatic test_wrap();
    bit seen = 0;
    redirect = 1'b1; redirect_pc = 32'hFFFF_FFFD;
    tick();
    redirect = 1'b0;
    #1;
    n_tests++;
    if (imem_addr !== 32'hFFFF_FFFC) begin
      n_fail++; $display("FAIL wrap_align: got addr=%h, required fffffffc", imem_addr);
    end
    for (int i = 0; i < 10 && !seen; i++) begin
      if (imem_req && imem_gnt) seen = 1; else tick();
    end
    tick();
    n_tests++;
    if (!seen || imem_addr !== 32'h0) begin
      n_fail++; $display("FAIL wrap_next: got granted=%b addr=%h, required 1 00000000", seen, imem_addr);
    end
    tick(8);
  endtask

  task automatic test_gnt_stall();
    logic [31:0] a;
    imem_gnt = 1'b0;
    tick(3);
    a = imem_addr;
    n_tests++;
    if (imem_req !== 1'b1) begin
      n_fail++; $display("FAIL gstall_req: got req=%b, required 1", imem_req);
    end
    for (int i = 0; i < 5; i++) begin
      tick();
      n_tests++;
      if (imem_req !== 1'b1 || imem_addr !== a) begin
        n_fail++; $display("FAIL gstall_hold: got req=%b addr=%h, required 1 %h", imem_req, imem_addr, a);
      end
    end
    imem_gnt = 1'b1;
    tick();
    n_tests++;
    if (imem_addr !== a + 32'd4) begin
      n_fail++; $display("FAIL gstall_advance: got addr=%h, required %h", imem_addr, a + 32'd4);
    end
    tick(6);
  endtask

  task automatic test_drain();
    imem_gnt = 1'b0;
    for (int i = 0; i < 10 && exp_q.size() != 0; i++) tick();
    tick();
    n_tests++;
    if (exp_q.size() != 0 || pend.size() != 0 || instr_valid !== 1'b0) begin
      n_fail++; $display("FAIL drain: got outstanding=%0d pending=%0d valid=%b, required 0 0 0",
                         exp_q.size(), pend.size(), instr_valid);
    end
  endtask

  task automatic test_reset_mid();
    imem_gnt = 1'b1;
    tick(5);
    rst_n = 1'b0;
    #1;
    n_tests++;
    if (imem_req !== 1'b0 || instr_valid !== 1'b0 || instr !== 32'h0 || instr_pc !== 32'h0) begin
      n_fail++; $display("FAIL midreset: got req=%b valid=%b instr=%h pc=%h, required 0 0 0 0",
                         imem_req, instr_valid, instr, instr_pc);
    end
    tick(2);
    rst_n = 1'b1;
    tick();
    n_tests++;
    if (imem_req !== 1'b1 || imem_addr !== RST_PC) begin
      n_fail++; $display("FAIL midreset_restart: got req=%b addr=%h, required 1 %h", imem_req, imem_addr, RST_PC);
    end
    tick(10);
  endtask

  initial begin
    test_reset();
    test_stream_decode();
    test_ready_stall();
    test_redirect_flush();
    test_redirect_rvalid_pop();
    test_wrap();
    test_gnt_stall();
    test_drain();
    test_reset_mid();
    test_drain();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running at 100000, required finish");
    $fatal(1);
  end

endmodule
